// File: rtl/counter_modn_ctl.sv
// counter_modn_ctl -- parametrised modulo-N counter for the 100 MHz domain.
//
// Counts 0..MOD-1 up or down. A prescaler turns PRESCALE enabled cycles into
// one count step. At a boundary the counter either wraps or saturates.
// Synchronous clear and load are provided. A terminal-count pulse and a
// sticky overflow flag report boundary events.
//
// Optional feature macro: COUNTER_BCD_EN. When it is defined, a BCD mirror of
// `out` with DIGITS digits is added on port `bcd`.
//
// Parameters: MOD (modulus), WIDTH (count width), PRESCALE (enabled cycles
//             per step), DIGITS (BCD digits, used only with COUNTER_BCD_EN)
// Ports:
//   clk_100M  clock, rising edge
//   rst       asynchronous active-high reset
//   en        count enable, gates the prescaler
//   up        1 = count up, 0 = count down
//   sat       1 = saturate at boundary, 0 = wrap
//   load      synchronous load of load_val (clamped to MOD-1)
//   load_val  value to load
//   clr       synchronous clear of count, prescaler and ovf
//   clr_ovf   clears ovf (a simultaneous new overflow wins)
//   out       registered count value
//   tick      one-cycle pulse on every count step
//   tc        one-cycle pulse when a step hits a boundary
//   ovf       sticky overflow / clamp flag
//   bcd       BCD image of out (COUNTER_BCD_EN only)
module counter_modn_ctl #(
  parameter int MOD      = 100,
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 1,
  parameter int DIGITS   = 2
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc,
`ifdef COUNTER_BCD_EN
  output logic             ovf,
  output logic [4*DIGITS-1:0] bcd
`else
  output logic             ovf
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Terminal values held as WIDTH-bit constants so every compare is
  // width-exact, including MOD == 2**WIDTH where MOD itself does not fit.
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD - 1);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);

  // Elaboration-time guard on the parameter set.
  if ((MOD < 2) || (PRESCALE < 1) || (DIGITS < 1) || ((2 ** WIDTH) < MOD)) begin : g_param_error
    $error("counter_modn_ctl: illegal parameter combination");
  end

  logic [WIDTH-1:0] out_reg;
  logic [PW-1:0]    presc_reg;
  logic             tick_reg;
  logic             tc_reg;
  logic             ovf_reg;

  logic step;
  logic at_max;
  logic at_zero;
  logic boundary;
  logic load_clamp;

  assign at_max     = (out_reg == MAX_VAL);
  assign at_zero    = (out_reg == '0);
  assign step       = en && (presc_reg == PRESC_MAX);
  assign boundary   = up ? at_max : at_zero;
  assign load_clamp = (load_val > MAX_VAL);

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      out_reg   <= '0;
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (clr) begin
      out_reg   <= '0;
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (load) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      tc_reg    <= 1'b0;
      out_reg   <= load_clamp ? MAX_VAL : load_val;
      ovf_reg   <= (ovf_reg & ~clr_ovf) | load_clamp;
    end else begin
      tick_reg <= step;
      tc_reg   <= step & boundary;
      ovf_reg  <= (ovf_reg & ~clr_ovf) | (step & boundary);
      if (en) begin
        presc_reg <= step ? '0 : presc_reg + PW'(1);
      end
      if (step) begin
        if (up) begin
          if (!at_max) begin
            out_reg <= out_reg + WIDTH'(1);
          end else if (!sat) begin
            out_reg <= '0;
          end
        end else begin
          if (!at_zero) begin
            out_reg <= out_reg - WIDTH'(1);
          end else if (!sat) begin
            out_reg <= MAX_VAL;
          end
        end
      end
    end
  end

  assign out  = out_reg;
  assign tick = tick_reg;
  assign tc   = tc_reg;
  assign ovf  = ovf_reg;

`ifdef COUNTER_BCD_EN
  // Double-dabble conversion, used only for loads and boundary wraps.
  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] bin);
    logic [4*DIGITS-1:0] acc;
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5) begin
          acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
      end
      acc = {acc[4*DIGITS-2:0], bin[i]};
    end
    return acc;
  endfunction

  localparam logic [4*DIGITS-1:0] BCD_MAX = to_bcd(MAX_VAL);

  logic [4*DIGITS-1:0] bcd_reg;
  logic [4*DIGITS-1:0] bcd_inc;
  logic [4*DIGITS-1:0] bcd_dec;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   borrow;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Decimal ripple increment/decrement, one digit per generate slice.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] digit;
    assign digit = bcd_reg[4*gi +: 4];
    assign bcd_inc[4*gi +: 4] = carry[gi]  ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
    assign bcd_dec[4*gi +: 4] = borrow[gi] ? ((digit == 4'd0) ? 4'd9 : digit - 4'd1) : digit;
    if (gi < DIGITS - 1) begin : g_chain
      assign carry[gi+1]  = carry[gi]  & (digit == 4'd9);
      assign borrow[gi+1] = borrow[gi] & (digit == 4'd0);
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      bcd_reg <= '0;
    end else if (clr) begin
      bcd_reg <= '0;
    end else if (load) begin
      bcd_reg <= to_bcd(load_clamp ? MAX_VAL : load_val);
    end else if (step) begin
      if (up) begin
        if (!at_max) begin
          bcd_reg <= bcd_inc;
        end else if (!sat) begin
          bcd_reg <= '0;
        end
      end else begin
        if (!at_zero) begin
          bcd_reg <= bcd_dec;
        end else if (!sat) begin
          bcd_reg <= BCD_MAX;
        end
      end
    end
  end

  assign bcd = bcd_reg;
`endif

endmodule

// File: doc/counter_modn_ctl.md
# counter_modn_ctl

Parametrised modulo-N counter; successor to the fixed mod-100 counter on the 100 MHz domain. Adds programmable modulus and width, a tick prescaler, up/down direction, wrap or saturate mode, synchronous load/clear, a terminal-count pulse and a sticky overflow flag. It is the time-base and event-count primitive for display, timer and stopwatch blocks. An optional BCD mirror drives 7-segment decoders directly.

## Interface
- MOD, 100, count modulus; count range 0..MOD-1; MOD >= 2
- WIDTH, 7, width of `out` and `load_val`; must satisfy 2^WIDTH >= MOD
- PRESCALE, 1, number of enabled cycles per count step; PRESCALE >= 1
- DIGITS, 2, BCD digits of `bcd`; requires 10^DIGITS >= MOD; used only with the BCD macro

Ports:
- clk_100M  in  1  clock, 100 MHz, all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; gates the prescaler
- up  in  1  direction: 1 counts up, 0 counts down
- sat  in  1  boundary mode: 1 saturates, 0 wraps
- load  in  1  synchronous load of `load_val`
- load_val  in  WIDTH  value to load
- clr  in  1  synchronous clear
- clr_ovf  in  1  clears `ovf`
- out  out  WIDTH  count value, registered
- tick  out  1  one-cycle pulse on every count step
- tc  out  1  one-cycle pulse when a step hits a boundary
- ovf  out  1  sticky overflow/clamp flag
- bcd  out  4*DIGITS  BCD image of `out`; present only with `COUNTER_BCD_EN`

## Operation
- Priority per edge: rst > clr > load > count step.
- Prescaler `presc` (internal, 0..PRESCALE-1):
  - Increments when en=1.
  - A step occurs when en=1 and presc==PRESCALE-1; presc then returns to 0.
  - en=0 freezes presc.
  - clr and load force presc=0.
  - With PRESCALE=1, a step occurs on every enabled cycle.
- Step with up=1:
  - out<MOD-1: out+1.
  - out==MOD-1: wrap to 0 (sat=0) or hold at MOD-1 (sat=1); either way tc=1 and ovf set.
- Step with up=0:
  - out>0: out-1.
  - out==0: wrap to MOD-1 (sat=0) or hold at 0 (sat=1); either way tc=1 and ovf set.
- tick=1 on every step, including a saturated hold.
- Load:
  - load_val<MOD: out=load_val.
  - load_val>=MOD: out=MOD-1 and ovf set.
  - No tick or tc on a load.
- clr: out=0, presc=0, ovf=0; no tick or tc.
- ovf:
  - Cleared by clr_ovf or clr.
  - If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Changes to up or sat take effect at the next step; there is no pending state.
- Arithmetic: width-exact WIDTH-bit compares against MOD-1 and 0; no modulo operator; no intermediate overflow even when MOD==2^WIDTH.

## Timing
- Reset values: out=0, tick=0, tc=0, ovf=0, presc=0, bcd=0.
- All outputs are registered and update on the same edge that takes the step, load or clear. Latency is one cycle from the qualifying input sample.
- tick and tc are high for exactly one cycle and never back-to-back unless PRESCALE=1 with consecutive steps.
- rst asserted mid-count clears everything immediately, without waiting for a clock edge. Counting resumes on the first edge after release, with presc starting from 0.
- load or clr in the same cycle as a step suppresses the step and its tick and tc.

## Configuration
- `COUNTER_BCD_EN` defined:
  - `bcd` port and DIGITS digit registers are compiled in.
  - Each digit counts 0..9 with carry on up and borrow on down.
  - Wrap and saturate follow `out` exactly.
  - Load converts `load_val`, after clamping, via a combinational double-dabble function.
  - `bcd` equals decimal(`out`) on every cycle.
- `COUNTER_BCD_EN` undefined: no `bcd` port and no BCD logic; all other behaviour is identical.

## Test plan
- Default params, en=1, up=1, sat=0, 3000 ns after reset pulse → out counts 0..99, wraps to 0; tc high on the cycle out becomes 0; ovf=1 after the first wrap.
- MOD=10, PRESCALE=4, en=1, up=0 from reset → first tick on cycle 4 with out=9, tc=1; thereafter out decrements every 4 cycles; en=0 for 2 cycles delays the next tick by exactly 2.
- MOD=100, sat=1, load load_val=98, up=1 → 98, 99, 99, 99; tick on each step; tc on each hold; sat=1 with up=0 after load 0 → out stays 0.
- load load_val=120 with MOD=100 → out=99, ovf=1; clr_ovf in the same cycle as a wrap event → ovf stays 1; clr_ovf alone → ovf=0.
- rst pulsed 1 ns mid-count at out=57 → out=0 immediately, no clock needed; load and step in the same cycle → load value wins, no tick.
- `COUNTER_BCD_EN` defined, MOD=100: count up through 09→10 and 99→00; count down 10→09; load 73 → bcd=8'h73 on the same edge as out=73.
